// File: rtl/pop_counter_bank.sv
// ---------------------------------------------------------------------------
// pop_counter_bank
//
// Bank of NUM_CH per-channel event counters. Each counter counts pop strobes
// of one downstream FIFO. When the datapath reports IDLE, a requester reads
// one count by index. The count comes back one cycle later with a valid
// strobe. A synchronous clear resets all counters and overflow flags.
// Each counter has a sticky overflow flag.
//
// Configuration macro:
//   POP_CNT_SAT_EN  undefined -> counters wrap modulo 2**CNT_W
//                   defined   -> counters saturate at 2**CNT_W-1
//   In both builds, ovf[i] is set on a pop taken at the maximum count.
//
// Ports:
//   clk       in   1        single clock, rising edge
//   reset_L   in   1        asynchronous active-low reset
//   IDLE      in   1        datapath idle; reads honoured only when 1
//   req       in   1        read request
//   idx       in   IDX_W    channel to read, sampled with req
//   clr       in   1        synchronous clear of all counters and ovf flags
//   pop       in   NUM_CH   per-channel pop strobe
//   valid     out  1        read response valid (one-cycle pulse)
//   data_out  out  CNT_W    returned count, 0 when valid=0
//   idx_err   out  1        one-cycle pulse: accepted req with idx >= NUM_CH
//   ovf       out  NUM_CH   sticky per-channel overflow flags
// ---------------------------------------------------------------------------
module pop_counter_bank #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              IDLE,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              clr,
    input  logic [NUM_CH-1:0] pop,
    output logic              valid,
    output logic [CNT_W-1:0]  data_out,
    output logic              idx_err,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_BUSY = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               idx_err_q, idx_err_d;
    logic [CNT_W-1:0]   data_q, data_d;

    logic               count_en_s;
    logic               accept_s;
    logic               idx_ok_s;
    logic [CNT_W-1:0]   rd_val_s;

    // Next-state logic: INIT leaves after one clock; BUSY/IDLE follow the IDLE input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_BUSY;
            ST_BUSY: begin
                if (IDLE) state_d = ST_IDLE;
                else      state_d = ST_BUSY;
            end
            ST_IDLE: begin
                if (!IDLE) state_d = ST_BUSY;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign count_en_s = (state_q != ST_INIT);

    // Counter and overflow next-state; clr beats pop on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = {CNT_W{1'b0}};
                ovf_d[i] = 1'b0;
            end else if (count_en_s && pop[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
`ifdef POP_CNT_SAT_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = {CNT_W{1'b0}};
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Read mux on pre-edge counter values, so a same-cycle pop or clr is not visible.
    always_comb begin
        rd_val_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) rd_val_s = cnt_q[i];
            else                  rd_val_s = rd_val_s;
        end
    end

    assign idx_ok_s = (32'(idx) < 32'(NUM_CH));
    assign accept_s = req && IDLE && (state_q == ST_IDLE);

    // Response next-state; data is forced to zero whenever valid is low.
    always_comb begin
        valid_d   = 1'b0;
        idx_err_d = 1'b0;
        data_d    = {CNT_W{1'b0}};
        if (accept_s) begin
            if (idx_ok_s) begin
                valid_d = 1'b1;
                data_d  = rd_val_s;
            end else begin
                idx_err_d = 1'b1;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, counters, flags and response registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_INIT;
            ovf_q     <= {NUM_CH{1'b0}};
            valid_q   <= 1'b0;
            idx_err_q <= 1'b0;
            data_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            idx_err_q <= idx_err_d;
            data_q    <= data_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;
    assign idx_err  = idx_err_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_pop_counter_bank.sv
module tb_pop_counter_bank;

    logic       clk;
    logic       reset_L;
    logic       IDLE;
    logic       req;
    logic [2:0] idx;
    logic       clr;
    logic [4:0] pop;
    logic       valid;
    logic [4:0] data_out;
    logic       idx_err;
    logic [4:0] ovf;

    pop_counter_bank #(.NUM_CH(5), .CNT_W(5), .IDX_W(3)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .IDLE     (IDLE),
        .req      (req),
        .idx      (idx),
        .clr      (clr),
        .pop      (pop),
        .valid    (valid),
        .data_out (data_out),
        .idx_err  (idx_err),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       e;
    } resp_t;

    resp_t      sb_q[$];
    int         vectors = 0;
    int         errs    = 0;

    // reference model state: 0=INIT 1=BUSY 2=IDLE
    logic [4:0] m_cnt [5];
    logic [4:0] m_ovf;
    int         m_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = 5'd0;
        m_ovf   = 5'd0;
        m_state = 0;
        sb_q.delete();
    endtask

    // One clock: predict response and model update, advance, compare.
    task automatic step(input string tag);
        resp_t r;
        r.v = 1'b0; r.d = 5'd0; r.e = 1'b0;
        if (req && IDLE && m_state == 2) begin
            if (idx < 3'd5) begin
                r.v = 1'b1;
                r.d = m_cnt[idx];
            end else begin
                r.e = 1'b1;
            end
        end
        sb_q.push_back(r);
        for (int i = 0; i < 5; i++) begin
            if (clr) begin
                m_cnt[i] = 5'd0;
                m_ovf[i] = 1'b0;
            end else if (m_state != 0 && pop[i]) begin
                if (m_cnt[i] == 5'd31) begin
                    m_ovf[i] = 1'b1;
`ifndef POP_CNT_SAT_EN
                    m_cnt[i] = 5'd0;
`endif
                end else begin
                    m_cnt[i] = m_cnt[i] + 5'd1;
                end
            end
        end
        case (m_state)
            0: m_state = 1;
            1: m_state = IDLE ? 2 : 1;
            2: m_state = IDLE ? 2 : 1;
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
        r = sb_q.pop_front();
        chk({tag, "_valid"},   {31'd0, valid},   {31'd0, r.v});
        chk({tag, "_data"},    {27'd0, data_out}, {27'd0, r.d});
        chk({tag, "_idx_err"}, {31'd0, idx_err}, {31'd0, r.e});
        chk({tag, "_ovf"},     {27'd0, ovf},     {27'd0, m_ovf});
    endtask

    initial begin
        reset_L = 1'b0; IDLE = 1'b0; req = 1'b0; idx = 3'd0; clr = 1'b0; pop = 5'd0;
        model_reset();

        // 1: reset with pops toggling, all outputs held at zero
        for (int c = 0; c < 5; c++) begin
            pop = (c % 2 == 0) ? 5'b11111 : 5'b00000;
            req = 1'b1; IDLE = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_valid",   {31'd0, valid},    32'd0);
            chk("rst_data",    {27'd0, data_out}, 32'd0);
            chk("rst_idx_err", {31'd0, idx_err},  32'd0);
            chk("rst_ovf",     {27'd0, ovf},      32'd0);
        end
        pop = 5'd0; req = 1'b0;
        reset_L = 1'b1;
        step("t1_init");
        step("t1_busy");
        req = 1'b1; idx = 3'd2;
        step("t1_rd2");
        chk("t1_rd2_valid_const", {31'd0, valid}, 32'd1);
        req = 1'b0;

        // 2: count channels 0 and 4 while busy, then three back-to-back reads
        IDLE = 1'b0; pop = 5'b10001;
        for (int c = 0; c < 3; c++) step("t2_pop");
        pop = 5'd0; IDLE = 1'b1;
        step("t2_toidle");
        req = 1'b1; idx = 3'd0;
        step("t2_rd0");
        chk("t2_rd0_const", {27'd0, data_out}, 32'd3);
        idx = 3'd4;
        step("t2_rd4");
        chk("t2_rd4_const", {27'd0, data_out}, 32'd3);
        idx = 3'd1;
        step("t2_rd1");
        chk("t2_rd1_const", {27'd0, data_out}, 32'd0);
        chk("t2_rd1_valid_const", {31'd0, valid}, 32'd1);

        // 3: req ignored while not idle; out-of-range index
        IDLE = 1'b0; idx = 3'd0;
        step("t3_busy_a");
        step("t3_busy_b");
        chk("t3_busy_const", {31'd0, valid}, 32'd0);
        req = 1'b0; IDLE = 1'b1;
        step("t3_toidle");
        req = 1'b1; idx = 3'd5;
        step("t3_bad_idx");
        chk("t3_idx_err_const", {31'd0, idx_err}, 32'd1);
        req = 1'b0;

        // 4: overflow on channel 3, then clear
        pop = 5'b01000;
        for (int c = 0; c < 33; c++) step("t4_pop");
        pop = 5'd0; req = 1'b1; idx = 3'd3;
        step("t4_rd3");
`ifdef POP_CNT_SAT_EN
        chk("t4_sat_const", {27'd0, data_out}, 32'd31);
`else
        chk("t4_wrap_const", {27'd0, data_out}, 32'd1);
`endif
        chk("t4_ovf_const", {27'd0, ovf}, 32'd8);
        req = 1'b0; clr = 1'b1;
        step("t4_clr");
        clr = 1'b0; req = 1'b1;
        step("t4_rd3_clr");
        chk("t4_clr_const", {27'd0, data_out}, 32'd0);
        req = 1'b0;

        // 5: same-cycle pop excluded from read, clr priority, read during clr
        pop = 5'b00100;
        for (int c = 0; c < 7; c++) step("t5_pop");
        req = 1'b1; idx = 3'd2;
        step("t5_rd_pop");
        chk("t5_rd7_const", {27'd0, data_out}, 32'd7);
        pop = 5'd0;
        step("t5_rd8");
        chk("t5_rd8_const", {27'd0, data_out}, 32'd8);
        clr = 1'b1;
        step("t5_rd_clr");
        chk("t5_preclr_const", {27'd0, data_out}, 32'd8);
        req = 1'b0; pop = 5'b00100;
        step("t5_clr_pop");
        clr = 1'b0; pop = 5'd0; req = 1'b1;
        step("t5_rd0");
        chk("t5_rd0_const", {27'd0, data_out}, 32'd0);
        req = 1'b0;

        // 6: async reset mid-cycle while a response is on the outputs
        pop = 5'b00010;
        step("t6_pop_a");
        step("t6_pop_b");
        pop = 5'd0; req = 1'b1; idx = 3'd1;
        step("t6_rd");
        chk("t6_rd_const", {27'd0, data_out}, 32'd2);
        req = 1'b0;
        #3;
        reset_L = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, valid},    32'd0);
        chk("t6_async_data",  {27'd0, data_out}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        step("t6_init");
        step("t6_busy");
        req = 1'b1; idx = 3'd1;
        step("t6_rd_after");
        chk("t6_after_const", {27'd0, data_out}, 32'd0);
        req = 1'b0;
        step("t6_tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
